duty_cycle_ctrl: RTL and testbench



---
 rtl/duty_ctrl_pkg.sv | 17 +
 rtl/btn_conditioner.sv | 44 ++++
 rtl/duty_cycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_duty_cycle_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/duty_ctrl_pkg.sv
// rtl/duty_ctrl_pkg.sv - shared types and widths for the duty-cycle push-button controller
package duty_ctrl_pkg;

  localparam int DUTY_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  typedef enum logic {
    INC,
    DEC
  } dir_t;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - raw active-low button to synchronized, debounced level plus press pulse
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;

  // Press pulse is registered together with the level flip so both are seen on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], ~i_btn_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/duty_cycle_ctrl.sv
// rtl/duty_cycle_ctrl.sv - push-button press/hold FSM stepping a saturating PWM duty count
// Optional auto-repeat on long hold: define DUTY_CTRL_AUTOREPEAT_EN.
module duty_cycle_ctrl
  import duty_ctrl_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int PWM_FREQ        = 50,
  parameter int DC_MIN          = 50_000,
  parameter int DC_MAX          = 100_000,
  parameter int DC_INIT         = 75_000,
  parameter int DC_STEP         = 5_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_inc_n,
  input  logic              btn_dec_n,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              at_min,
  output logic              at_max
);

  localparam int  PERIOD_COUNTS = CLK_FREQ / PWM_FREQ;
  localparam int  SUM_W         = DUTY_W + 1;
  localparam bit  CFG_OK        = (DC_MIN <= DC_INIT) && (DC_INIT <= DC_MAX) &&
                                  (DC_MAX <= PERIOD_COUNTS) && (DEBOUNCE_CYCLES > 0) &&
                                  (REPEAT_DELAY > 0) && (REPEAT_RATE > 0);

  if (!CFG_OK) begin : g_cfg_invalid
  end

  logic w_inc_lvl, w_inc_press, w_dec_lvl, w_dec_press;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_n(btn_inc_n),
    .o_level(w_inc_lvl), .o_press(w_inc_press)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_n(btn_dec_n),
    .o_level(w_dec_lvl), .o_press(w_dec_press)
  );

  state_t            r_state;
  dir_t              r_dir;
  logic [DUTY_W-1:0] r_duty;
  logic              r_upd, r_at_min, r_at_max;

`ifdef DUTY_CTRL_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  logic [RPT_W-1:0] r_cnt;
  logic             w_oth_lvl;
`endif

  dir_t              w_dir;
  logic              w_act_lvl, w_start_inc, w_start_dec, w_step;
  logic [SUM_W-1:0]  w_sum;
  logic [DUTY_W-1:0] w_inc_val, w_dec_val, w_next;

  // A press is only accepted while the other button is fully released.
  always_comb begin
    w_start_inc = w_inc_press & ~w_dec_lvl;
    w_start_dec = w_dec_press & ~w_inc_lvl;
    w_act_lvl   = (r_dir == INC) ? w_inc_lvl : w_dec_lvl;
`ifdef DUTY_CTRL_AUTOREPEAT_EN
    w_oth_lvl   = (r_dir == INC) ? w_dec_lvl : w_inc_lvl;
`endif
    w_dir = r_dir;
    if (r_state == IDLE) w_dir = w_start_inc ? INC : DEC;

    w_step = 1'b0;
    case (r_state)
      IDLE:   w_step = w_start_inc | w_start_dec;
`ifdef DUTY_CTRL_AUTOREPEAT_EN
      HOLD:   w_step = w_act_lvl & ~w_oth_lvl & (r_cnt == RPT_W'(REPEAT_DELAY - 1));
      REPEAT: w_step = w_act_lvl & ~w_oth_lvl & (r_cnt == RPT_W'(REPEAT_RATE - 1));
`endif
      default: w_step = 1'b0;
    endcase

    w_sum     = {1'b0, r_duty} + SUM_W'(DC_STEP);
    w_inc_val = (w_sum > SUM_W'(DC_MAX)) ? DUTY_W'(DC_MAX) : w_sum[DUTY_W-1:0];
    w_dec_val = ({1'b0, r_duty} < (SUM_W'(DC_MIN) + SUM_W'(DC_STEP))) ?
                DUTY_W'(DC_MIN) : (r_duty - DUTY_W'(DC_STEP));
    w_next    = (w_dir == INC) ? w_inc_val : w_dec_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dir    <= INC;
      r_duty   <= DUTY_W'(DC_INIT);
      r_upd    <= 1'b0;
      r_at_min <= (DC_INIT == DC_MIN);
      r_at_max <= (DC_INIT == DC_MAX);
`ifdef DUTY_CTRL_AUTOREPEAT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_upd <= 1'b0;
      if (w_step) begin
        r_duty   <= w_next;
        r_upd    <= (w_next != r_duty);
        r_at_min <= (w_next == DUTY_W'(DC_MIN));
        r_at_max <= (w_next == DUTY_W'(DC_MAX));
      end
      case (r_state)
        IDLE: begin
`ifdef DUTY_CTRL_AUTOREPEAT_EN
          r_cnt <= '0;
`endif
          if (w_step) begin
            r_dir   <= w_dir;
            r_state <= HOLD;
          end
        end
`ifdef DUTY_CTRL_AUTOREPEAT_EN
        HOLD: begin
          if (!w_act_lvl || w_oth_lvl) begin
            r_state <= IDLE;
          end else if (w_step) begin
            r_cnt   <= '0;
            r_state <= REPEAT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!w_act_lvl || w_oth_lvl) begin
            r_state <= IDLE;
          end else if (w_step) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`else
        HOLD: begin
          if (!w_act_lvl) r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign duty     = r_duty;
  assign duty_upd = r_upd;
  assign at_min   = r_at_min;
  assign at_max   = r_at_max;

endmodule

// File: tb/tb_duty_cycle_ctrl.sv
// tb/tb_duty_cycle_ctrl.sv - directed self-checking bench for duty_cycle_ctrl (honours DUTY_CTRL_AUTOREPEAT_EN)
module tb_duty_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_inc_n = 1'b1;
  logic        btn_dec_n = 1'b1;
  logic [31:0] duty;
  logic        duty_upd, at_min, at_max;

  int n_checks = 0;
  int n_err    = 0;
  int upd_cnt  = 0;
  int upd_base = 0;

`ifdef DUTY_CTRL_AUTOREPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  duty_cycle_ctrl #(
    .CLK_FREQ(1000), .PWM_FREQ(10),
    .DC_MIN(10), .DC_MAX(30), .DC_INIT(20), .DC_STEP(5),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n),
    .duty(duty), .duty_upd(duty_upd), .at_min(at_min), .at_max(at_max)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (duty_upd === 1'b1) upd_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tap(input bit inc, input int hold);
    if (inc) btn_inc_n = 1'b0; else btn_dec_n = 1'b0;
    cyc(hold);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    cyc(10);
  endtask

  initial begin
    cyc(3);
    chk("rst_duty", duty, 20);
    chk("rst_upd", {31'd0, duty_upd}, 0);
    chk("rst_min", {31'd0, at_min}, 0);
    chk("rst_max", {31'd0, at_max}, 0);
    rst_n = 1'b1;
    cyc(2);

    // single press: duty changes exactly 7 edges after the raw press
    upd_base = upd_cnt;
    btn_inc_n = 1'b0;
    cyc(6);
    chk("press_before", duty, 20);
    cyc(1);
    chk("press_duty", duty, 25);
    chk("press_upd_hi", {31'd0, duty_upd}, 1);
    cyc(1);
    chk("press_upd_lo", {31'd0, duty_upd}, 0);
    btn_inc_n = 1'b1;
    cyc(10);
    chk("press_hold_duty", duty, 25);
    chk("press_upd_cnt", upd_cnt - upd_base, 1);

    // 3-cycle glitch on dec never debounces
    upd_base = upd_cnt;
    btn_dec_n = 1'b0;
    cyc(3);
    btn_dec_n = 1'b1;
    cyc(10);
    chk("glitch_duty", duty, 25);
    chk("glitch_upd_cnt", upd_cnt - upd_base, 0);

    tap(1'b1, 8);
    chk("sat_inc30", duty, 30);
    chk("sat_at_max", {31'd0, at_max}, 1);
    upd_base = upd_cnt;
    tap(1'b1, 8);
    chk("sat_hold30", duty, 30);
    chk("sat_max_no_upd", upd_cnt - upd_base, 0);

    for (int i = 0; i < 4; i++) tap(1'b0, 8);
    chk("dec_to10", duty, 10);
    chk("dec_at_min", {31'd0, at_min}, 1);
    chk("dec_at_max", {31'd0, at_max}, 0);
    upd_base = upd_cnt;
    tap(1'b0, 8);
    chk("sat_min10", duty, 10);
    chk("sat_min_no_upd", upd_cnt - upd_base, 0);

    // long hold of inc from 10
    upd_base = upd_cnt;
    btn_inc_n = 1'b0;
    cyc(7);
    chk("rpt_t0", duty, 15);
    cyc(8);
    chk("rpt_t8", duty, RPT ? 32'd20 : 32'd15);
    cyc(4);
    chk("rpt_t12", duty, RPT ? 32'd25 : 32'd15);
    cyc(4);
    chk("rpt_t16", duty, RPT ? 32'd30 : 32'd15);
    chk("rpt_max", {31'd0, at_max}, RPT ? 32'd1 : 32'd0);
    btn_inc_n = 1'b1;
    cyc(10);
    chk("rpt_upd_cnt", upd_cnt - upd_base, RPT ? 32'd4 : 32'd1);

    // conflict: hold dec, then press inc while dec is held
    upd_base = upd_cnt;
    btn_dec_n = 1'b0;
    cyc(7);
    chk("conf_dec_step", duty, RPT ? 32'd25 : 32'd10);
    btn_inc_n = 1'b0;
    cyc(23);
    chk("conf_no_more", duty, RPT ? 32'd25 : 32'd10);
    chk("conf_upd_cnt", upd_cnt - upd_base, 1);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    cyc(10);

    // both buttons pressed on the same cycle
    upd_base = upd_cnt;
    btn_inc_n = 1'b0;
    btn_dec_n = 1'b0;
    cyc(20);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    cyc(10);
    chk("both_duty", duty, RPT ? 32'd25 : 32'd10);
    chk("both_upd_cnt", upd_cnt - upd_base, 0);

    // reset asserted mid-cycle with inc held across it
    btn_inc_n = 1'b0;
    cyc(10);
    chk("pre_rst_duty", duty, RPT ? 32'd30 : 32'd15);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_duty", duty, 20);
    chk("mid_rst_upd", {31'd0, duty_upd}, 0);
    chk("mid_rst_min", {31'd0, at_min}, 0);
    chk("mid_rst_max", {31'd0, at_max}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("held_rst_before", duty, 20);
    cyc(1);
    chk("held_rst_press", duty, 25);
    btn_inc_n = 1'b1;
    cyc(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
